// File: rtl/sobel_frame_seq.sv
// Frame-level sequencer placed in front of sobel_ctrl.
// Admits exactly one frame of gray pixels per start request and tracks the input
// raster position. Window results are counted to detect frame completion. A
// shadow threshold is committed only at frame start, and a drain watchdog bounds
// the wait for trailing results.
module sobel_frame_seq #(
    parameter int IMAGE_WIDTH   = 1920,
    parameter int IMAGE_HEIGHT  = 1080,
    parameter int DATA_WIDTH    = 8,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           cfg_thresh,
    input  logic                  cfg_load,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  res_valid,
    input  logic                  res_zero,
    input  logic                  res_cov,
    output logic [15:0]           thresh_active,
    output logic                  sof,
    output logic                  eol,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_timeout,
    output logic                  err_overrun,
    output logic [15:0]           frame_cnt
);

    localparam int TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int XW    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int YW    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int IW    = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] C_FULL = CW'(TOTAL);
    localparam logic [IW-1:0] I_LAST = IW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   in_x_q, in_x_d;
    logic [YW-1:0]   in_y_q, in_y_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [15:0]     pend_q, pend_d;
    logic [15:0]     thresh_q, thresh_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            frame_done_q, frame_done_d;
    logic            busy_q, busy_d;
    logic            err_to_q, err_to_d;
    logic            err_ov_q, err_ov_d;

    logic            run_s;
    logic            hs_in_s;
    logic            res_ev_s;
    logic            last_px_s;
    logic            cnt_full_s;

    // Zero-latency stream gating, handshake and result decode
    always_comb begin
        run_s      = (state_q == ST_RUN);
        m_data     = s_data;
        m_valid    = s_valid & run_s;
        s_ready    = m_ready & run_s;
        hs_in_s    = s_valid & m_ready & run_s;
        res_ev_s   = res_valid & (res_zero | res_cov);
        cnt_full_s = (out_cnt_q == C_FULL);
        sof        = hs_in_s & (in_x_q == {XW{1'b0}}) & (in_y_q == {YW{1'b0}});
        eol        = hs_in_s & (in_x_q == X_LAST);
        last_px_s  = hs_in_s & (in_x_q == X_LAST) & (in_y_q == Y_LAST);
    end

    // Next-state, counters, shadow threshold and status flags
    always_comb begin
        state_d      = state_q;
        in_x_d       = in_x_q;
        in_y_d       = in_y_q;
        out_cnt_d    = out_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        thresh_d     = thresh_q;
        frame_cnt_d  = frame_cnt_q;
        err_to_d     = err_to_q;
        err_ov_d     = err_ov_q | (res_ev_s & cnt_full_s);
        pend_d       = cfg_load ? cfg_thresh : pend_q;

        // results only count while a frame is in flight and never past a full frame
        if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && res_ev_s && !cnt_full_s) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end else begin
            out_cnt_d = out_cnt_q;
        end

        if (res_ev_s) begin
            idle_cnt_d = {IW{1'b0}};
        end else if (state_q == ST_DRAIN) begin
            idle_cnt_d = idle_cnt_q + IW'(1);
        end else begin
            idle_cnt_d = idle_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d    = ST_RUN;
                    // a load in the same cycle as start is the value that takes effect
                    thresh_d   = cfg_load ? cfg_thresh : pend_q;
                    in_x_d     = {XW{1'b0}};
                    in_y_d     = {YW{1'b0}};
                    out_cnt_d  = {CW{1'b0}};
                    idle_cnt_d = {IW{1'b0}};
                    err_to_d   = 1'b0;
                    err_ov_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (hs_in_s) begin
                    if (in_x_q == X_LAST) begin
                        in_x_d = {XW{1'b0}};
                        in_y_d = (in_y_q == Y_LAST) ? {YW{1'b0}} : (in_y_q + YW'(1));
                    end else begin
                        in_x_d = in_x_q + XW'(1);
                    end
                end else begin
                    in_x_d = in_x_q;
                end
                if (last_px_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (out_cnt_d == C_FULL) begin
                    state_d = ST_DONE;
                end else if (!res_ev_s && (idle_cnt_q == I_LAST)) begin
                    err_to_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // abort wins over everything: drop the frame, keep the error history
        if (abort) begin
            state_d    = ST_IDLE;
            in_x_d     = {XW{1'b0}};
            in_y_d     = {YW{1'b0}};
            out_cnt_d  = {CW{1'b0}};
            idle_cnt_d = {IW{1'b0}};
            err_to_d   = err_to_q;
        end else begin
            state_d = state_d;
        end

        frame_done_d = (state_d == ST_DONE);
        if (state_d == ST_DONE) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            in_x_q       <= {XW{1'b0}};
            in_y_q       <= {YW{1'b0}};
            out_cnt_q    <= {CW{1'b0}};
            idle_cnt_q   <= {IW{1'b0}};
            pend_q       <= 16'd0;
            thresh_q     <= 16'd0;
            frame_cnt_q  <= 16'd0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_to_q     <= 1'b0;
            err_ov_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_x_q       <= in_x_d;
            in_y_q       <= in_y_d;
            out_cnt_q    <= out_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            pend_q       <= pend_d;
            thresh_q     <= thresh_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            err_to_q     <= err_to_d;
            err_ov_q     <= err_ov_d;
        end
    end

    assign thresh_active = thresh_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign err_timeout   = err_to_q;
    assign err_overrun   = err_ov_q;
    assign frame_cnt     = frame_cnt_q;

endmodule
